// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a 16x4 dual-port RAM with registered read.
// Define FIFO_ERR_EN to add a sticky err output for dropped pushes and ignored pops.
module fifo_ctrl #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [DATA_W-1:0] ram_q,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef FIFO_ERR_EN
  output logic              err,
`endif
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE    = AE_THRESH[ADDR_W:0];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_valid;
  logic              w_push_ok, w_pop_ok;
  // Reset overrides the client, so nothing reaches the RAM during the reset cycle.
  assign w_pop_ok     = reset_L & pop & ~empty;
  assign w_push_ok    = reset_L & push & (~full | w_pop_ok);
  assign ram_we       = w_push_ok;
  assign ram_waddr    = r_wptr;
  assign ram_wdata    = data_in;
  assign ram_re       = w_pop_ok;
  assign ram_raddr    = r_rptr;
  assign data_out     = ram_q;
  assign valid_out    = r_valid;
  assign count        = r_count;
  assign full         = r_count == DEPTH;
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= AF;
  assign almost_empty = r_count <= AE;
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
      r_count <= (w_push_ok && !w_pop_ok) ? r_count + 1'b1 :
                 (!w_push_ok && w_pop_ok) ? r_count - 1'b1 : r_count;
      r_valid <= w_pop_ok;
    end
  end
`ifdef FIFO_ERR_EN
  logic r_err;
  assign err = r_err;
  always_ff @(posedge clk) begin
    if (!reset_L) r_err <= 1'b0;
    else r_err <= r_err | (push & full & ~pop) | (pop & empty);
  end
`endif
endmodule
